// File: rtl/lfsr_interval_timer.sv
// ---------------------------------------------------------------------------
// lfsr_interval_timer
//
// Purpose:
//   Generates one-cycle event pulses at pseudo-random intervals. In LOAD it
//   samples a 5-bit value from an upstream LFSR and clamps it up to
//   MIN_INTERVAL. In COUNT it counts that many time-base ticks. It then
//   fires a single pulse in FIRE and reloads while enable stays high.
//
// Parameters:
//   MIN_INTERVAL  lowest interval in ticks (legal range 1..31)
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   reset        in   synchronous active-high reset
//   lfsr[4:0]    in   pseudo-random value, sampled only in LOAD
//   enable       in   level-sensitive run request
//   tick         in   one-cycle time-base strobe
//   pulse        out  one-cycle strobe at the end of each interval
//   busy         out  high in LOAD, COUNT and FIRE
//   interval[4:0]out  interval length currently in use
//   pulse_count  out  pulses issued (saturating at 255)
//
// Configuration macro:
//   LFSR_TIMER_PULSE_COUNT_EN  when defined, builds the saturating pulse
//                              counter; when undefined, pulse_count is a
//                              constant 0 and no counter register exists.
// ---------------------------------------------------------------------------
module lfsr_interval_timer #(
    parameter int MIN_INTERVAL = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] lfsr,
    input  logic       enable,
    input  logic       tick,
    output logic       pulse,
    output logic       busy,
    output logic [4:0] interval,
    output logic [7:0] pulse_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COUNT = 2'd2,
        S_FIRE  = 2'd3
    } state_t;

    localparam logic [4:0] C_MIN_INTERVAL = 5'(MIN_INTERVAL);

    state_t     r_state;
    logic       r_pulse;
    logic       r_busy;
    logic [4:0] r_interval;
    logic [4:0] r_counter;
    logic [4:0] w_load_value;

    // Clamp the random sample so the interval is never shorter than the
    // minimum; a value of 0 therefore also maps to MIN_INTERVAL.
    assign w_load_value = (lfsr < C_MIN_INTERVAL) ? C_MIN_INTERVAL : lfsr;

`ifdef LFSR_TIMER_PULSE_COUNT_EN
    logic [7:0] r_pulse_count;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pulse    <= 1'b0;
            r_busy     <= 1'b0;
            r_interval <= 5'd0;
            r_counter  <= 5'd0;
`ifdef LFSR_TIMER_PULSE_COUNT_EN
            r_pulse_count <= 8'd0;
`endif
        end else begin
            // pulse is only ever high for the single FIRE cycle
            r_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end

                S_LOAD: begin
                    // tick is deliberately ignored here
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_interval <= w_load_value;
                        r_counter  <= w_load_value;
                        r_state    <= S_COUNT;
                    end
                end

                S_COUNT: begin
                    // Dropping enable wins over a simultaneous final tick,
                    // so an abort never produces a pulse.
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (tick) begin
                        // counter is loaded with >= 1, so the <= 1 test
                        // also stops it from ever wrapping below zero
                        if (r_counter <= 5'd1) begin
                            r_counter <= 5'd0;
                            r_state   <= S_FIRE;
                            r_pulse   <= 1'b1;
`ifdef LFSR_TIMER_PULSE_COUNT_EN
                            if (r_pulse_count != 8'hFF) begin
                                r_pulse_count <= r_pulse_count + 8'd1;
                            end
`endif
                        end else begin
                            r_counter <= r_counter - 5'd1;
                        end
                    end
                end

                S_FIRE: begin
                    // tick is ignored; reload immediately if still enabled
                    if (enable) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse    = r_pulse;
    assign busy     = r_busy;
    assign interval = r_interval;

`ifdef LFSR_TIMER_PULSE_COUNT_EN
    assign pulse_count = r_pulse_count;
`else
    assign pulse_count = 8'd0;
`endif

endmodule

// File: tb/tb_lfsr_interval_timer.sv
// ---------------------------------------------------------------------------
// tb_lfsr_interval_timer
//
// Directed bench for lfsr_interval_timer (MIN_INTERVAL = 3). Each scenario
// pushes the cycle numbers at which pulses are expected onto a scoreboard
// queue; a monitor pops and compares them on every falling edge where pulse
// is high. Any pulse with an empty queue is reported as unexpected.
// ---------------------------------------------------------------------------
module tb_lfsr_interval_timer;

    logic       clk;
    logic       reset;
    logic [4:0] lfsr;
    logic       enable;
    logic       tick;
    logic       pulse;
    logic       busy;
    logic [4:0] interval;
    logic [7:0] pulse_count;

    int unsigned cyc;
    int unsigned c0;
    int          n_pass;
    int          n_fail;
    int          n_total;
    int          model_cnt;
    int unsigned exp_q[$];

    lfsr_interval_timer #(
        .MIN_INTERVAL(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lfsr       (lfsr),
        .enable     (enable),
        .tick       (tick),
        .pulse      (pulse),
        .busy       (busy),
        .interval   (interval),
        .pulse_count(pulse_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk_step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {17'd0, pulse, busy, interval, pulse_count}, 32'd0);
    endtask

    initial begin
        n_pass    = 0;
        n_fail    = 0;
        n_total   = 0;
        model_cnt = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        tick      = 1'b0;
        lfsr      = 5'd0;

        // scoreboard monitor: pulses, busy during FIRE, pulse_count model
        fork
            forever begin
                @(negedge clk);
                if (reset) begin
                    model_cnt = 0;
                end else if (pulse) begin
                    if (model_cnt < 255) model_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", {31'd0, pulse}, 32'd0);
                    end else begin
                        chk("pulse_cycle", cyc, exp_q.pop_front());
                    end
                    chk("busy_in_fire", {31'd0, busy}, 32'd1);
`ifdef LFSR_TIMER_PULSE_COUNT_EN
                    chk("pulse_count_run", {24'd0, pulse_count}, model_cnt);
`else
                    chk("pulse_count_run", {24'd0, pulse_count}, 32'd0);
`endif
                end
            end
        join_none

        // reset held for two edges, then idle with enable low
        clk_step(2);
        chk_idle("reset_state");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            clk_step(1);
            chk_idle("idle_hold");
        end
        $display("txn idle_after_reset done at cycle %0d", cyc);

        // lfsr=5, tick every cycle: pulse period 7, lfsr ignored outside LOAD
        lfsr   = 5'd5;
        tick   = 1'b1;
        enable = 1'b1;
        c0     = cyc;
        exp_q.push_back(c0 + 7);
        exp_q.push_back(c0 + 14);
        exp_q.push_back(c0 + 21);
        clk_step(1);
        chk("load_busy", {31'd0, busy}, 32'd1);
        chk("load_interval_unchanged", {27'd0, interval}, 32'd0);
        clk_step(1);
        chk("interval_5", {27'd0, interval}, 32'd5);
        lfsr = 5'd9;
        clk_step(1);
        chk("interval_hold_5", {27'd0, interval}, 32'd5);
        clk_step(4);
        chk("fire_pulse", {31'd0, pulse}, 32'd1);
        lfsr = 5'd5;
        clk_step(14);
        enable = 1'b0;
        clk_step(1);
        chk("fire_to_idle_busy", {31'd0, busy}, 32'd0);
        chk("fire_to_idle_interval", {27'd0, interval}, 32'd5);
        tick = 1'b0;
        $display("txn lfsr5_period7 done at cycle %0d", cyc);

        // lfsr=0 clamps to 3; tick every 4th cycle
        lfsr = 5'd0;
        c0   = cyc;
        exp_q.push_back(c0 + 12);
        for (int k = 1; k <= 13; k++) begin
            enable = (k <= 12);
            tick   = ((k % 4) == 0);
            clk_step(1);
            if (k == 2) chk("interval_min", {27'd0, interval}, 32'd3);
        end
        tick = 1'b0;
        chk("min_run_idle_busy", {31'd0, busy}, 32'd0);
        $display("txn lfsr0_min3 done at cycle %0d", cyc);

        // lfsr=31, abort after 10 ticks with tick still high
        lfsr   = 5'd31;
        tick   = 1'b1;
        enable = 1'b1;
        clk_step(12);
        chk("interval_31", {27'd0, interval}, 32'd31);
        chk("count_busy", {31'd0, busy}, 32'd1);
        enable = 1'b0;
        clk_step(1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_pulse", {31'd0, pulse}, 32'd0);
        chk("abort_interval", {27'd0, interval}, 32'd31);
        tick = 1'b0;
        clk_step(2);
        $display("txn lfsr31_abort done at cycle %0d", cyc);

        // reset mid-COUNT with counter=4
        lfsr   = 5'd7;
        tick   = 1'b1;
        enable = 1'b1;
        clk_step(5);
        chk("pre_reset_interval", {27'd0, interval}, 32'd7);
        reset = 1'b1;
        clk_step(1);
        chk_idle("reset_mid_count");
        reset  = 1'b0;
        enable = 1'b0;
        clk_step(3);
        chk_idle("after_reset_idle");
        $display("txn reset_mid_count done at cycle %0d", cyc);

        // reset on the edge that would have entered FIRE: no pulse
        lfsr   = 5'd3;
        enable = 1'b1;
        clk_step(4);
        reset = 1'b1;
        clk_step(1);
        chk_idle("reset_at_fire_edge");
        reset  = 1'b0;
        enable = 1'b0;
        clk_step(2);
        chk_idle("after_reset2_idle");
        $display("txn reset_at_fire done at cycle %0d", cyc);

        // 300 consecutive pulses with interval 3 (lfsr=1 clamps up)
        lfsr   = 5'd1;
        tick   = 1'b1;
        enable = 1'b1;
        c0     = cyc;
        for (int i = 0; i < 300; i++) exp_q.push_back(c0 + 5 + 5 * i);
        clk_step(1500);
        enable = 1'b0;
        clk_step(1);
        tick = 1'b0;
`ifdef LFSR_TIMER_PULSE_COUNT_EN
        chk("pulse_count_sat", {24'd0, pulse_count}, 32'd255);
`else
        chk("pulse_count_sat", {24'd0, pulse_count}, 32'd0);
`endif
        chk("final_busy", {31'd0, busy}, 32'd0);
        clk_step(3);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("txn pulse_count_300 done at cycle %0d", cyc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lfsr_interval_timer.md
LFSR_INTERVAL_TIMER -- requirements
Module: lfsr_interval_timer

Interface
REQ-001 SHALL have parameter MIN_INTERVAL, default 1, the lowest interval in ticks; legal range 1..31.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port lfsr, input, 5 bits: pseudo-random value from the upstream 5-bit LFSR.
REQ-005 SHALL have port enable, input, 1 bit: run request; level-sensitive.
REQ-006 SHALL have port tick, input, 1 bit: one-cycle time-base strobe.
REQ-007 SHALL have port pulse, output, 1 bit: one-cycle event strobe at the end of each interval.
REQ-008 SHALL have port busy, output, 1 bit: high while an interval is loaded or counting.
REQ-009 SHALL have port interval, output, 5 bits: interval length currently in use.
REQ-010 SHALL have port pulse_count, output, 8 bits: number of pulses issued.

Function
REQ-011 SHALL implement the states IDLE, LOAD, COUNT and FIRE, registered and updated only on the rising edge of clk.
REQ-012 IDLE: pulse=0, busy=0; enable=1 -> LOAD on the next edge; otherwise remain in IDLE.
REQ-013 LOAD: on the edge leaving LOAD, interval and the down-counter SHALL capture max(lfsr, MIN_INTERVAL); next state COUNT; busy=1.
REQ-014 LOAD SHALL ignore tick; LOAD SHALL go to IDLE without capturing if enable=0.
REQ-015 COUNT: each cycle with tick=1 SHALL decrement the counter by 1; tick=1 while counter==1 -> FIRE.
REQ-016 COUNT with enable=0 SHALL abort to IDLE on the next edge with no pulse, even if tick=1 in that cycle; interval holds its last value.
REQ-017 FIRE: pulse=1 for exactly one cycle, busy=1; tick is ignored; next state LOAD if enable=1, else IDLE.
REQ-018 Latency: pulse SHALL be high in the cycle immediately after the cycle carrying the interval-th accepted tick.
REQ-019 With enable held high and tick=1 every cycle, the pulse period SHALL be interval+2 cycles.
REQ-020 lfsr=0 or lfsr<MIN_INTERVAL SHALL load MIN_INTERVAL; lfsr=31 SHALL load 31. No arithmetic wraps.
REQ-021 A new interval SHALL be sampled from lfsr only in LOAD; changes to lfsr at any other time have no effect.
REQ-022 pulse, busy, interval and pulse_count SHALL be driven directly from registers (no combinational path from inputs).

Reset
REQ-023 reset=1 at a clock edge SHALL force IDLE, pulse=0, busy=0, interval=0, pulse_count=0, counter=0.
REQ-024 Reset SHALL take priority over every other input in every state, including mid-COUNT and in FIRE; no pulse follows.
REQ-025 After reset is released, operation SHALL resume from IDLE on the first edge at which enable=1.

Configuration
REQ-026 Macro LFSR_TIMER_PULSE_COUNT_EN defined: pulse_count SHALL increment by 1 on each FIRE, saturating at 255.
REQ-027 Macro LFSR_TIMER_PULSE_COUNT_EN undefined: pulse_count SHALL be constant 0 and no counter register SHALL be built; all other behaviour is unchanged.

Verification
REQ-028 Reset held for 2 cycles, then released with enable=0 -> all outputs 0 and state stays IDLE for 20 cycles.
REQ-029 lfsr=5, enable=1, tick every cycle -> interval=5; pulse is high 1 cycle, 7 cycles after the LOAD edge; period is 7 cycles while enable is held.
REQ-030 lfsr=0 with MIN_INTERVAL=3, tick every 4th cycle -> interval=3; pulse follows the 3rd accepted tick by 1 cycle.
REQ-031 lfsr=31, enable dropped after 10 ticks -> IDLE next edge, no pulse, busy=0, interval stays 31.
REQ-032 reset asserted mid-COUNT (counter=4) -> next edge IDLE with all outputs 0; no pulse.
REQ-033 With the macro defined, 300 consecutive pulses -> pulse_count=255; with the macro undefined -> pulse_count=0 throughout.
